// File: rtl/cfg_seq_pkg.sv
// cfg_seq_pkg: sequencer states and kernel IDs shared by the config ID sequencer and its users
package cfg_seq_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, SETTLE} state_e;
  localparam logic [7:0] ID_NONE = 8'd0;
  localparam logic [7:0] ID_MAC = 8'd1;
  localparam logic [7:0] ID_MUL = 8'd2;
endpackage

// File: rtl/config_token_counter.sv
// config_token_counter: saturating up/down count of datapath tokens in flight
// ports: clk_i/rst_ni clock and async active-low reset, clear_i sync clear,
//        inc/dec one token in/out this cycle, count current value, is_zero count == 0
module config_token_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 is_zero
);
  assign is_zero = count == '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count <= '0;
    else if (clear_i) count <= '0;
    else if (inc && !dec && !(&count)) count <= count + 1'b1;
    else if (dec && !inc && !is_zero) count <= count - 1'b1;
  end
endmodule

// File: rtl/config_id_sequencer.sv
// config_id_sequencer: drives the kernel-select ID, draining in-flight tokens and settling before each switch
// ports: clk_i/rst_ni clock and async active-low reset, clear_i sync soft clear,
//        req_valid_i/req_id_i/req_ready_o reconfiguration request handshake,
//        tok_in_i/tok_out_i datapath token entry/exit, id_o kernel ID to the configurator,
//        cfg_valid_o ID stable, busy_o switch in progress, done_o/err_o completion/reject pulses
module config_id_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int ID_WIDTH      = 8,
  parameter int NUM_IDS       = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                req_valid_i,
  input  logic [ID_WIDTH-1:0] req_id_i,
  output logic                req_ready_o,
  input  logic                tok_in_i,
  input  logic                tok_out_i,
  output logic [ID_WIDTH-1:0] id_o,
  output logic                cfg_valid_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  state_e state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d, pend_q, pend_d;
  logic [SW-1:0] settle_q, settle_d;
  logic done_q, done_d, err_q, err_d;
  logic [CNT_WIDTH-1:0] count;
  logic is_zero, zero_next, id_bad;
  config_token_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .inc    (tok_in_i),
    .dec    (tok_out_i),
    .count  (count),
    .is_zero(is_zero)
  );
  // drain ends on the edge where this cycle's token traffic leaves the count at zero
  assign zero_next = is_zero ? !(tok_in_i && !tok_out_i)
                             : count == CNT_WIDTH'(1) && tok_out_i && !tok_in_i;
  assign id_bad = req_id_i == '0 || req_id_i > ID_WIDTH'(NUM_IDS);
  assign req_ready_o = state_q == IDLE;
  assign cfg_valid_o = req_ready_o && id_q != '0;
  assign busy_o = !req_ready_o;
  assign id_o = id_q;
  assign done_o = done_q;
  assign err_o = err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      id_q     <= ID_WIDTH'(ID_NONE);
      pend_q   <= '0;
      settle_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      pend_q   <= pend_d;
      settle_q <= settle_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    pend_d   = pend_q;
    settle_d = settle_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (clear_i) begin
      state_d  = IDLE;
      pend_d   = '0;
      settle_d = '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          if (id_bad) err_d = 1'b1;
          else if (req_id_i == id_q) done_d = 1'b1;
          else begin
            pend_d  = req_id_i;
            state_d = DRAIN;
          end
        end
        DRAIN: if (zero_next) begin
          id_d     = pend_q;
          settle_d = SW'(SETTLE_CYCLES);
          state_d  = SETTLE;
        end
        SETTLE: if (settle_q == SW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else settle_d = settle_q - 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: doc/config_id_sequencer.md
Name: config_id_sequencer

Overview:
- Initiator side of the kernel-select interface: owns and drives the 8-bit ID that the configurator decodes into multiplexer selects (1 = MACnetwork, 2 = MULnetwork).
- Accepts reconfiguration requests from the HWPE controller over a valid/ready handshake.
- Before switching the ID, drains in-flight datapath tokens, then holds a settle window, then signals completion.
- Sits between the controller/register file and the dataflow kernel.

Parameters:
- ID_WIDTH, 8, width of the kernel ID.
- NUM_IDS, 2, valid IDs are 1..NUM_IDS.
- SETTLE_CYCLES, 2, cycles the new ID is held before cfg_valid_o rises; legal range ≥1.
- CNT_WIDTH, 8, width of the in-flight token counter.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- clear_i  input  1  synchronous soft clear.
- req_valid_i  input  1  reconfiguration request valid.
- req_id_i  input  ID_WIDTH  requested kernel ID.
- req_ready_o  output  1  request accepted when high with req_valid_i.
- tok_in_i  input  1  one token entered the datapath this cycle.
- tok_out_i  input  1  one token left the datapath this cycle.
- id_o  output  ID_WIDTH  ID to the configurator.
- cfg_valid_o  output  1  id_o stable; upstream may issue tokens.
- busy_o  output  1  FSM not in IDLE.
- done_o  output  1  one-cycle pulse: request completed.
- err_o  output  1  one-cycle pulse: invalid ID rejected.

Behaviour:
- Reset (async, active-low): state = IDLE, id_o = 0 (no kernel selected), cfg_valid_o = 0, in-flight count = 0, done_o = 0, err_o = 0, busy_o = 0. req_ready_o is 1 after reset.
- req_ready_o = (state == IDLE). A request handshake occurs at a rising edge where req_valid_i & req_ready_o.
- cfg_valid_o = (state == IDLE) & (id_o != 0). It is combinational from registered state.
- In-flight counter:
  - tok_in_i only: +1. tok_out_i only: −1. Both asserted: unchanged.
  - Saturates at 2^CNT_WIDTH−1 on increment and at 0 on decrement; both saturation cases are silently ignored.
  - Tokens that arrive while cfg_valid_o = 0 are a protocol violation but are still counted.
- FSM states are IDLE, DRAIN, SETTLE. Let T be the handshake edge.
  - Invalid ID (0 or > NUM_IDS): stay in IDLE; err_o = 1 in cycle T+1; id_o unchanged.
  - ID equal to the current id_o: stay in IDLE; done_o = 1 in cycle T+1; no drain.
  - Otherwise: go to DRAIN at T+1 and latch the pending ID.
- DRAIN: wait until count == 0, with tok_out_i decrements applied first. On the edge where the count reads 0: load id_o with the pending ID, load the settle counter with SETTLE_CYCLES, and go to SETTLE.
- SETTLE: decrement the settle counter each cycle. When it reaches 1, go to IDLE at the next edge and assert done_o for that first IDLE cycle.
- Latency with an empty pipeline: id_o changes at T+2, and done_o = cfg_valid_o = 1 at T+2+SETTLE_CYCLES (T+4 at the default).
- done_o and err_o are registered pulses. They are never high simultaneously.
- clear_i (sync):
  - State → IDLE; count → 0; settle counter → 0; pending ID discarded.
  - id_o retained, so cfg_valid_o = (id_o != 0) on the next cycle.
  - No done_o/err_o pulse is generated.
  - clear_i takes priority over a same-cycle handshake; the request is not accepted.
- Asynchronous reset mid-DRAIN or mid-SETTLE: immediate return to reset values; id_o = 0.

Decomposition:
- Package cfg_seq_pkg: state enum (IDLE, DRAIN, SETTLE), ID_NONE = 0, ID_MAC = 1, ID_MUL = 2.
- Sub-module config_token_counter: saturating up/down counter with clear. It outputs count and an is_zero flag.

Test Plan:
- Reset, then request id 1 with no tokens → req_ready_o falls at T+1, id_o = 1 at T+2, done_o and cfg_valid_o = 1 at T+4, busy_o high for T+1..T+3.
- With id_o = 1, issue 3 tok_in, then request id 2, then 3 tok_out spaced 2 cycles apart → id_o stays 1 until the count reaches 0, then becomes 2; done_o 2 cycles later.
- Request id 0, then id 3 → err_o pulses at T+1 each time; id_o unchanged; state stays IDLE.
- With id_o = 2, request id 2 → done_o at T+1; cfg_valid_o never drops.
- Same-cycle tok_in & tok_out with count 1 → count stays 1. tok_out at count 0 → count stays 0.
- Assert clear_i in SETTLE during an id 1→2 switch → IDLE next cycle, id_o = 2 retained, no done_o. Assert rst_ni low in DRAIN → id_o = 0 and cfg_valid_o = 0 asynchronously.
